tl_a_rr_arbiter: RTL and testbench

- Shares one TileLink A channel (64-bit data, 32-bit address, 3-bit source) between two client ports, using round-robin arbitration.
- Holds the grant for the full length of a multi-beat message.
- Routes the returning D channel to the correct client by source bit 2.
- Sits directly upstream of the tile's TL master clock-crossing coupler: its out_a_* and out_d_* ports connect straight to the coupler's in-side A and D channels.

---
 rtl/tl_a_rr_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 tb/tb_tl_a_rr_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_a_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tl_a_rr_arbiter
// Two-client round-robin arbiter for a TileLink A channel (64-bit data,
// 32-bit address, 3-bit source). A grant is held for every beat of a
// multi-beat message. The returning D channel is steered to the client
// selected by source bit 2, and its payload is broadcast to both clients.
//
// Optional build macro: TL_ARB_STATS_EN
//   When defined, the block adds saturating 16-bit counters:
//   - stat_msgs0 and stat_msgs1 count completed messages per client.
//   - stat_stall counts cycles where A is valid but not ready.
// -----------------------------------------------------------------------------
module tl_a_rr_arbiter #(
   parameter int BEAT_BYTES = 8,
   parameter int MAX_SIZE   = 6
) (
   input  logic        clock,
   input  logic        reset,

   // client 0 A channel
   input  logic        in0_a_valid,
   output logic        in0_a_ready,
   input  logic [2:0]  in0_a_opcode,
   input  logic [2:0]  in0_a_param,
   input  logic [3:0]  in0_a_size,
   input  logic [2:0]  in0_a_source,
   input  logic [31:0] in0_a_address,
   input  logic [7:0]  in0_a_mask,
   input  logic [63:0] in0_a_data,
   input  logic        in0_a_corrupt,

   // client 1 A channel
   input  logic        in1_a_valid,
   output logic        in1_a_ready,
   input  logic [2:0]  in1_a_opcode,
   input  logic [2:0]  in1_a_param,
   input  logic [3:0]  in1_a_size,
   input  logic [2:0]  in1_a_source,
   input  logic [31:0] in1_a_address,
   input  logic [7:0]  in1_a_mask,
   input  logic [63:0] in1_a_data,
   input  logic        in1_a_corrupt,

   // shared A channel towards the clock-crossing coupler
   output logic        out_a_valid,
   input  logic        out_a_ready,
   output logic [2:0]  out_a_opcode,
   output logic [2:0]  out_a_param,
   output logic [3:0]  out_a_size,
   output logic [2:0]  out_a_source,
   output logic [31:0] out_a_address,
   output logic [7:0]  out_a_mask,
   output logic [63:0] out_a_data,
   output logic        out_a_corrupt,

   // shared D channel from the clock-crossing coupler
   input  logic        out_d_valid,
   output logic        out_d_ready,
   input  logic [2:0]  out_d_opcode,
   input  logic [1:0]  out_d_param,
   input  logic [3:0]  out_d_size,
   input  logic [2:0]  out_d_source,
   input  logic [1:0]  out_d_sink,
   input  logic        out_d_denied,
   input  logic [63:0] out_d_data,
   input  logic        out_d_corrupt,

   // client 0 D channel
   output logic        in0_d_valid,
   input  logic        in0_d_ready,
   output logic [2:0]  in0_d_opcode,
   output logic [1:0]  in0_d_param,
   output logic [3:0]  in0_d_size,
   output logic [2:0]  in0_d_source,
   output logic [1:0]  in0_d_sink,
   output logic        in0_d_denied,
   output logic [63:0] in0_d_data,
   output logic        in0_d_corrupt,

   // client 1 D channel
   output logic        in1_d_valid,
   input  logic        in1_d_ready,
   output logic [2:0]  in1_d_opcode,
   output logic [1:0]  in1_d_param,
   output logic [3:0]  in1_d_size,
   output logic [2:0]  in1_d_source,
   output logic [1:0]  in1_d_sink,
   output logic        in1_d_denied,
   output logic [63:0] in1_d_data,
   output logic        in1_d_corrupt,

`ifdef TL_ARB_STATS_EN
   output logic [15:0] stat_msgs0,
   output logic [15:0] stat_msgs1,
   output logic [15:0] stat_stall,
`endif

   // sticky protocol error flags
   output logic        err_source,
   output logic        err_size
);

   // lg2 of the beat width and the largest legal size, as 4-bit values for size math
   localparam logic [3:0] LP_BEAT_LG  = 4'($clog2(BEAT_BYTES));
   localparam logic [3:0] LP_MAX_SIZE = 4'(MAX_SIZE);

   // ST_IDLE: free to arbitrate; ST_BURST: grant locked to r_owner mid-message
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   // Number of beats in a message: data-carrying opcodes (0..3) span
   // 2^(size-lg2(beat)) beats, everything else is a single beat.
   // Oversized requests are clamped so the counter never overflows.
   function automatic logic [3:0] f_total_beats(input logic [2:0] opcode,
                                                input logic [3:0] size);
      logic [3:0] v_size;
      logic [3:0] v_total;
      v_size = (size > LP_MAX_SIZE) ? LP_MAX_SIZE : size;
      if ((opcode <= 3'd3) && (v_size > LP_BEAT_LG)) begin
         v_total = 4'd1 << (v_size - LP_BEAT_LG);
      end else begin
         v_total = 4'd1;
      end
      return v_total;
   endfunction

`ifdef TL_ARB_STATS_EN
   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [15:0] f_sat_inc(input logic [15:0] value);
      logic [15:0] v_next;
      if (value == 16'hFFFF) begin
         v_next = value;
      end else begin
         v_next = value + 16'd1;
      end
      return v_next;
   endfunction
`endif

   state_t      r_state;
   state_t      w_state_next;
   logic        r_owner;
   logic        w_owner_next;
   logic [2:0]  r_beats_left;
   logic [2:0]  w_beats_next;
   logic        r_rr_ptr;
   logic        w_rr_next;
   logic        r_err_source;
   logic        r_err_size;

   logic        w_lock;
   logic        w_winner;
   logic        w_win_valid;
   logic        w_fire;
   logic [3:0]  w_total;
   logic        w_last;
   logic        w_err_source_set;
   logic        w_err_size_set;
   logic        w_d_dst;

   assign w_lock = (r_state == ST_BURST);

   // Pick the granted client: the lock owner, else the sole requester, else rr_ptr on a tie
   always_comb begin
      w_winner = 1'b0;
      if (w_lock) begin
         w_winner = r_owner;
      end else if (in0_a_valid && in1_a_valid) begin
         w_winner = r_rr_ptr;
      end else if (in1_a_valid) begin
         w_winner = 1'b1;
      end else begin
         w_winner = 1'b0;
      end
   end

   // Steer the granted client's valid and payload onto the shared A channel
   always_comb begin
      w_win_valid   = 1'b0;
      out_a_opcode  = 3'd0;
      out_a_param   = 3'd0;
      out_a_size    = 4'd0;
      out_a_source  = 3'd0;
      out_a_address = 32'd0;
      out_a_mask    = 8'd0;
      out_a_data    = 64'd0;
      out_a_corrupt = 1'b0;
      case (w_winner)
         1'b0: begin
            w_win_valid   = in0_a_valid;
            out_a_opcode  = in0_a_opcode;
            out_a_param   = in0_a_param;
            out_a_size    = in0_a_size;
            out_a_source  = in0_a_source;
            out_a_address = in0_a_address;
            out_a_mask    = in0_a_mask;
            out_a_data    = in0_a_data;
            out_a_corrupt = in0_a_corrupt;
         end
         1'b1: begin
            w_win_valid   = in1_a_valid;
            out_a_opcode  = in1_a_opcode;
            out_a_param   = in1_a_param;
            out_a_size    = in1_a_size;
            out_a_source  = in1_a_source;
            out_a_address = in1_a_address;
            out_a_mask    = in1_a_mask;
            out_a_data    = in1_a_data;
            out_a_corrupt = in1_a_corrupt;
         end
         default: begin
            w_win_valid   = 1'b0;
         end
      endcase
   end

   // valid depends only on client valids and state, never on out_a_ready
   assign out_a_valid = w_win_valid & ~reset;
   assign in0_a_ready = out_a_ready & ~w_winner & ~reset;
   assign in1_a_ready = out_a_ready &  w_winner & ~reset;

   assign w_fire  = out_a_valid & out_a_ready;
   assign w_total = f_total_beats(out_a_opcode, out_a_size);
   // final beat of a message: the counter runs out, or an unlocked single-beat fire
   assign w_last  = w_fire & (w_lock ? (r_beats_left <= 3'd1) : (w_total == 4'd1));

   // Next-state for the burst lock, beat counter and round-robin pointer
   always_comb begin
      w_state_next = r_state;
      w_owner_next = r_owner;
      w_beats_next = r_beats_left;
      w_rr_next    = r_rr_ptr;
      case (r_state)
         ST_IDLE: begin
            if (w_fire) begin
               if (w_total > 4'd1) begin
                  w_state_next = ST_BURST;
                  w_owner_next = w_winner;
                  w_beats_next = 3'(w_total - 4'd1);
               end else begin
                  w_rr_next    = ~w_winner;
               end
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         ST_BURST: begin
            if (w_fire) begin
               if (r_beats_left > 3'd1) begin
                  w_beats_next = r_beats_left - 3'd1;
               end else begin
                  w_state_next = ST_IDLE;
                  w_beats_next = 3'd0;
                  w_rr_next    = ~r_owner;
               end
            end else begin
               w_state_next = ST_BURST;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_beats_next = 3'd0;
         end
      endcase
   end

   // Arbitration state register; reset abandons any partial burst
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_owner      <= 1'b0;
         r_beats_left <= 3'd0;
         r_rr_ptr     <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_owner      <= w_owner_next;
         r_beats_left <= w_beats_next;
         r_rr_ptr     <= w_rr_next;
      end
   end

   // Error conditions: source outside the client's half, oversized first beat
   always_comb begin
      w_err_source_set = 1'b0;
      w_err_size_set   = 1'b0;
      if (w_fire) begin
         w_err_source_set = (out_a_source[2] != w_winner);
         w_err_size_set   = ~w_lock & (out_a_size > LP_MAX_SIZE);
      end else begin
         w_err_source_set = 1'b0;
         w_err_size_set   = 1'b0;
      end
   end

   // Sticky error flags; they report only and never block traffic
   always_ff @(posedge clock) begin
      if (reset) begin
         r_err_source <= 1'b0;
         r_err_size   <= 1'b0;
      end else begin
         r_err_source <= r_err_source | w_err_source_set;
         r_err_size   <= r_err_size   | w_err_size_set;
      end
   end

   assign err_source = r_err_source;
   assign err_size   = r_err_size;

`ifdef TL_ARB_STATS_EN
   logic [15:0] r_stat_msgs0;
   logic [15:0] r_stat_msgs1;
   logic [15:0] r_stat_stall;

   // Saturating per-client completion counters and A stall counter
   always_ff @(posedge clock) begin
      if (reset) begin
         r_stat_msgs0 <= 16'd0;
         r_stat_msgs1 <= 16'd0;
         r_stat_stall <= 16'd0;
      end else begin
         if (w_last && !w_winner) begin
            r_stat_msgs0 <= f_sat_inc(r_stat_msgs0);
         end
         if (w_last && w_winner) begin
            r_stat_msgs1 <= f_sat_inc(r_stat_msgs1);
         end
         if (out_a_valid && !out_a_ready) begin
            r_stat_stall <= f_sat_inc(r_stat_stall);
         end
      end
   end

   assign stat_msgs0 = r_stat_msgs0;
   assign stat_msgs1 = r_stat_msgs1;
   assign stat_stall = r_stat_stall;
`endif

   // D channel: source bit 2 names the destination client
   assign w_d_dst     = out_d_source[2];
   assign in0_d_valid = out_d_valid & ~w_d_dst;
   assign in1_d_valid = out_d_valid &  w_d_dst;
   assign out_d_ready = w_d_dst ? in1_d_ready : in0_d_ready;

   // D payload is broadcast; only valid is steered
   assign in0_d_opcode  = out_d_opcode;
   assign in0_d_param   = out_d_param;
   assign in0_d_size    = out_d_size;
   assign in0_d_source  = out_d_source;
   assign in0_d_sink    = out_d_sink;
   assign in0_d_denied  = out_d_denied;
   assign in0_d_data    = out_d_data;
   assign in0_d_corrupt = out_d_corrupt;
   assign in1_d_opcode  = out_d_opcode;
   assign in1_d_param   = out_d_param;
   assign in1_d_size    = out_d_size;
   assign in1_d_source  = out_d_source;
   assign in1_d_sink    = out_d_sink;
   assign in1_d_denied  = out_d_denied;
   assign in1_d_data    = out_d_data;
   assign in1_d_corrupt = out_d_corrupt;

endmodule

// File: tb/tb_tl_a_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tl_a_rr_arbiter
// Self-checking bench for tl_a_rr_arbiter. Expected A/D results are queued
// when stimulus is applied and compared on the following falling edge.
// -----------------------------------------------------------------------------
module tb_tl_a_rr_arbiter;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic        in0_a_valid, in0_a_ready, in1_a_valid, in1_a_ready;
   logic [2:0]  in0_a_opcode, in0_a_param, in0_a_source, in1_a_opcode, in1_a_param, in1_a_source;
   logic [3:0]  in0_a_size, in1_a_size;
   logic [31:0] in0_a_address, in1_a_address;
   logic [7:0]  in0_a_mask, in1_a_mask;
   logic [63:0] in0_a_data, in1_a_data;
   logic        in0_a_corrupt, in1_a_corrupt;
   logic        out_a_valid, out_a_ready;
   logic [2:0]  out_a_opcode, out_a_param, out_a_source;
   logic [3:0]  out_a_size;
   logic [31:0] out_a_address;
   logic [7:0]  out_a_mask;
   logic [63:0] out_a_data;
   logic        out_a_corrupt;
   logic        out_d_valid, out_d_ready;
   logic [2:0]  out_d_opcode, out_d_source;
   logic [1:0]  out_d_param, out_d_sink;
   logic [3:0]  out_d_size;
   logic        out_d_denied, out_d_corrupt;
   logic [63:0] out_d_data;
   logic        in0_d_valid, in0_d_ready, in1_d_valid, in1_d_ready;
   logic [2:0]  in0_d_opcode, in0_d_source, in1_d_opcode, in1_d_source;
   logic [1:0]  in0_d_param, in0_d_sink, in1_d_param, in1_d_sink;
   logic [3:0]  in0_d_size, in1_d_size;
   logic        in0_d_denied, in0_d_corrupt, in1_d_denied, in1_d_corrupt;
   logic [63:0] in0_d_data, in1_d_data;
   logic        err_source, err_size;
`ifdef TL_ARB_STATS_EN
   logic [15:0] stat_msgs0, stat_msgs1, stat_stall;
`endif

   tl_a_rr_arbiter dut (
      .clock(clock), .reset(reset),
      .in0_a_valid(in0_a_valid), .in0_a_ready(in0_a_ready), .in0_a_opcode(in0_a_opcode),
      .in0_a_param(in0_a_param), .in0_a_size(in0_a_size), .in0_a_source(in0_a_source),
      .in0_a_address(in0_a_address), .in0_a_mask(in0_a_mask), .in0_a_data(in0_a_data),
      .in0_a_corrupt(in0_a_corrupt),
      .in1_a_valid(in1_a_valid), .in1_a_ready(in1_a_ready), .in1_a_opcode(in1_a_opcode),
      .in1_a_param(in1_a_param), .in1_a_size(in1_a_size), .in1_a_source(in1_a_source),
      .in1_a_address(in1_a_address), .in1_a_mask(in1_a_mask), .in1_a_data(in1_a_data),
      .in1_a_corrupt(in1_a_corrupt),
      .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
      .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
      .out_a_address(out_a_address), .out_a_mask(out_a_mask), .out_a_data(out_a_data),
      .out_a_corrupt(out_a_corrupt),
      .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
      .out_d_param(out_d_param), .out_d_size(out_d_size), .out_d_source(out_d_source),
      .out_d_sink(out_d_sink), .out_d_denied(out_d_denied), .out_d_data(out_d_data),
      .out_d_corrupt(out_d_corrupt),
      .in0_d_valid(in0_d_valid), .in0_d_ready(in0_d_ready), .in0_d_opcode(in0_d_opcode),
      .in0_d_param(in0_d_param), .in0_d_size(in0_d_size), .in0_d_source(in0_d_source),
      .in0_d_sink(in0_d_sink), .in0_d_denied(in0_d_denied), .in0_d_data(in0_d_data),
      .in0_d_corrupt(in0_d_corrupt),
      .in1_d_valid(in1_d_valid), .in1_d_ready(in1_d_ready), .in1_d_opcode(in1_d_opcode),
      .in1_d_param(in1_d_param), .in1_d_size(in1_d_size), .in1_d_source(in1_d_source),
      .in1_d_sink(in1_d_sink), .in1_d_denied(in1_d_denied), .in1_d_data(in1_d_data),
      .in1_d_corrupt(in1_d_corrupt),
`ifdef TL_ARB_STATS_EN
      .stat_msgs0(stat_msgs0), .stat_msgs1(stat_msgs1), .stat_stall(stat_stall),
`endif
      .err_source(err_source), .err_size(err_size)
   );

   int checks = 0;
   int errors = 0;

   // per-client A stimulus copies; expected payloads are built from these
   logic        c_valid[2];
   logic [2:0]  c_op[2];
   logic [2:0]  c_param[2];
   logic [3:0]  c_size[2];
   logic [2:0]  c_src[2];
   logic [31:0] c_addr[2];
   logic [7:0]  c_mask[2];
   logic [63:0] c_data[2];
   logic        c_corrupt[2];

   typedef struct {
      logic valid; logic win; logic r0; logic r1; logic crdy; logic cpay;
   } a_exp_t;
   typedef struct {
      logic v0; logic v1; logic rdy;
   } d_exp_t;
   typedef struct {
      logic v0; logic v1; logic ardy;
      logic e_valid; logic e_win; logic e_r0; logic e_r1; logic e_crdy; logic e_cpay;
   } a_vec_t;
   typedef struct {
      logic dv; logic [2:0] src; logic r0; logic r1;
      logic e_v0; logic e_v1; logic e_rdy;
   } d_vec_t;

   a_exp_t a_q[$];
   string  a_nq[$];
   d_exp_t d_q[$];
   string  d_nq[$];
   a_vec_t a_vec[13];
   d_vec_t d_vec[6];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] a_pay_exp(input logic w);
      int n;
      n = w ? 1 : 0;
      return 128'({c_addr[n], c_data[n], c_src[n], c_op[n], c_size[n], c_mask[n], c_param[n], c_corrupt[n]});
   endfunction

   function automatic logic [127:0] a_pay_act();
      return 128'({out_a_address, out_a_data, out_a_source, out_a_opcode, out_a_size,
                   out_a_mask, out_a_param, out_a_corrupt});
   endfunction

   task automatic apply_a();
      in0_a_valid = c_valid[0]; in0_a_opcode = c_op[0]; in0_a_param = c_param[0];
      in0_a_size = c_size[0]; in0_a_source = c_src[0]; in0_a_address = c_addr[0];
      in0_a_mask = c_mask[0]; in0_a_data = c_data[0]; in0_a_corrupt = c_corrupt[0];
      in1_a_valid = c_valid[1]; in1_a_opcode = c_op[1]; in1_a_param = c_param[1];
      in1_a_size = c_size[1]; in1_a_source = c_src[1]; in1_a_address = c_addr[1];
      in1_a_mask = c_mask[1]; in1_a_data = c_data[1]; in1_a_corrupt = c_corrupt[1];
   endtask

   task automatic drive_a(input int n, input logic v, input logic [2:0] op,
                          input logic [3:0] sz, input logic [2:0] src);
      c_valid[n] = v; c_op[n] = op; c_size[n] = sz; c_src[n] = src;
      apply_a();
   endtask

   // queue the expectation, let the cycle settle, compare, advance to next cycle
   task automatic a_step(input string nm, input logic v, input logic w, input logic r0,
                         input logic r1, input logic crdy, input logic cpay);
      a_exp_t e;
      a_exp_t g;
      string  gn;
      e.valid = v; e.win = w; e.r0 = r0; e.r1 = r1; e.crdy = crdy; e.cpay = cpay;
      a_q.push_back(e);
      a_nq.push_back(nm);
      @(negedge clock);
      g  = a_q.pop_front();
      gn = a_nq.pop_front();
      chk({gn, ".valid"}, 128'(out_a_valid), 128'(g.valid));
      if (g.crdy) begin
         chk({gn, ".rdy0"}, 128'(in0_a_ready), 128'(g.r0));
         chk({gn, ".rdy1"}, 128'(in1_a_ready), 128'(g.r1));
      end
      if (g.cpay) begin
         chk({gn, ".payload"}, a_pay_act(), a_pay_exp(g.win));
      end
      @(posedge clock);
      #1;
   endtask

   task automatic d_step(input string nm, input logic v0, input logic v1, input logic rdy);
      d_exp_t e;
      d_exp_t g;
      string  gn;
      logic [127:0] pay;
      e.v0 = v0; e.v1 = v1; e.rdy = rdy;
      d_q.push_back(e);
      d_nq.push_back(nm);
      pay = 128'({out_d_opcode, out_d_param, out_d_size, out_d_source, out_d_sink,
                  out_d_denied, out_d_data, out_d_corrupt});
      @(negedge clock);
      g  = d_q.pop_front();
      gn = d_nq.pop_front();
      chk({gn, ".d_valid0"}, 128'(in0_d_valid), 128'(g.v0));
      chk({gn, ".d_valid1"}, 128'(in1_d_valid), 128'(g.v1));
      chk({gn, ".d_ready"},  128'(out_d_ready), 128'(g.rdy));
      chk({gn, ".d_pay0"}, 128'({in0_d_opcode, in0_d_param, in0_d_size, in0_d_source,
                                 in0_d_sink, in0_d_denied, in0_d_data, in0_d_corrupt}), pay);
      chk({gn, ".d_pay1"}, 128'({in1_d_opcode, in1_d_param, in1_d_size, in1_d_source,
                                 in1_d_sink, in1_d_denied, in1_d_data, in1_d_corrupt}), pay);
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      // unlocked vectors; rr pointer evolves from reset value 0
      a_vec[0]  = '{1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1,1'b0,1'b1,1'b1};
      a_vec[1]  = '{1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b1,1'b1,1'b1};
      a_vec[2]  = '{1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1,1'b0,1'b1,1'b1};
      a_vec[3]  = '{1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b1,1'b1,1'b1};
      a_vec[4]  = '{1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b1};
      a_vec[5]  = '{1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b1};
      a_vec[6]  = '{1'b0,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b1,1'b1,1'b1};
      a_vec[7]  = '{1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1,1'b0,1'b1,1'b1};
      a_vec[8]  = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
      a_vec[9]  = '{1'b1,1'b0,1'b1, 1'b1,1'b0,1'b1,1'b0,1'b1,1'b1};
      a_vec[10] = '{1'b1,1'b1,1'b1, 1'b1,1'b1,1'b0,1'b1,1'b1,1'b1};
      a_vec[11] = '{1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b1};
      a_vec[12] = '{1'b1,1'b1,1'b1, 1'b1,1'b0,1'b1,1'b0,1'b1,1'b1};
      // D routing vectors
      d_vec[0] = '{1'b1, 3'b101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      d_vec[1] = '{1'b1, 3'b101, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      d_vec[2] = '{1'b1, 3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      d_vec[3] = '{1'b1, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      d_vec[4] = '{1'b0, 3'b101, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      d_vec[5] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

      c_param[0] = 3'd1; c_mask[0] = 8'hFF; c_corrupt[0] = 1'b0;
      c_addr[0] = 32'h1000_0080; c_data[0] = 64'h0B0B_1111_2222_3333;
      c_param[1] = 3'd2; c_mask[1] = 8'h0F; c_corrupt[1] = 1'b1;
      c_addr[1] = 32'h2000_0040; c_data[1] = 64'hA1A1_4444_5555_6666;
      out_d_valid = 1'b0; out_d_opcode = 3'd1; out_d_param = 2'd2; out_d_size = 4'd3;
      out_d_source = 3'd0; out_d_sink = 2'd1; out_d_denied = 1'b1;
      out_d_data = 64'hD00D_CAFE_0123_4567; out_d_corrupt = 1'b0;
      in0_d_ready = 1'b0; in1_d_ready = 1'b0;

      // reset state: requests present but nothing granted
      reset = 1'b1;
      out_a_ready = 1'b1;
      drive_a(0, 1'b1, 3'd4, 4'd3, 3'b000);
      drive_a(1, 1'b1, 3'd4, 4'd3, 3'b100);
      @(posedge clock);
      #1;
      @(negedge clock);
      chk("rst.valid", 128'(out_a_valid), 128'(1'b0));
      chk("rst.rdy0", 128'(in0_a_ready), 128'(1'b0));
      chk("rst.rdy1", 128'(in1_a_ready), 128'(1'b0));
      chk("rst.err_source", 128'(err_source), 128'(1'b0));
      chk("rst.err_size", 128'(err_size), 128'(1'b0));
      @(posedge clock);
      #1;
      reset = 1'b0;

      // single-beat Gets: alternation, stalls, lone requesters
      for (int i = 0; i < 13; i++) begin
         c_valid[0] = a_vec[i].v0;
         c_valid[1] = a_vec[i].v1;
         apply_a();
         out_a_ready = a_vec[i].ardy;
         a_step($sformatf("vec%0d", i), a_vec[i].e_valid, a_vec[i].e_win, a_vec[i].e_r0,
                a_vec[i].e_r1, a_vec[i].e_crdy, a_vec[i].e_cpay);
      end
      chk("vec.err_source", 128'(err_source), 128'(1'b0));
      chk("vec.err_size", 128'(err_size), 128'(1'b0));

      // D routing with A idle
      c_valid[0] = 1'b0; c_valid[1] = 1'b0; apply_a();
      for (int i = 0; i < 6; i++) begin
         out_d_valid = d_vec[i].dv; out_d_source = d_vec[i].src;
         in0_d_ready = d_vec[i].r0; in1_d_ready = d_vec[i].r1;
         out_d_data = out_d_data + 64'd1;
         d_step($sformatf("dvec%0d", i), d_vec[i].e_v0, d_vec[i].e_v1, d_vec[i].e_rdy);
      end
      out_d_valid = 1'b0;

      // 8-beat PutFull from in0 holds the grant; in1 follows on cycle 9
      do_reset();
      out_a_ready = 1'b1;
      drive_a(0, 1'b1, 3'd0, 4'd6, 3'b000);
      drive_a(1, 1'b1, 3'd4, 4'd3, 3'b100);
      out_d_valid = 1'b1; out_d_source = 3'b100; in1_d_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a_step($sformatf("burst8.b%0d", i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      end
      a_step("burst8.in1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      a_step("burst8.rr0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      out_d_valid = 1'b0;

      // 4-beat PutFull from in1 with ready toggling; lock survives stalls
      do_reset();
      drive_a(0, 1'b0, 3'd4, 4'd3, 3'b000);
      drive_a(1, 1'b1, 3'd0, 4'd5, 3'b100);
      out_a_ready = 1'b1;
      a_step("burst4.c1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      drive_a(0, 1'b1, 3'd4, 4'd3, 3'b000);
      for (int c = 2; c <= 7; c++) begin
         out_a_ready = (c % 2 == 1) ? 1'b1 : 1'b0;
         a_step($sformatf("burst4.c%0d", c), 1'b1, 1'b1, 1'b0, out_a_ready, 1'b1, 1'b1);
      end
      out_a_ready = 1'b1;
      a_step("burst4.unlock", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

      // error flags: bad source, then oversized PutFull clamped to 8 beats
      do_reset();
      drive_a(1, 1'b0, 3'd4, 4'd3, 3'b100);
      drive_a(0, 1'b1, 3'd4, 4'd3, 3'b100);
      out_a_ready = 1'b1;
      a_step("err.get", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("err.src_set", 128'(err_source), 128'(1'b1));
      chk("err.size_clear", 128'(err_size), 128'(1'b0));
      drive_a(0, 1'b1, 3'd0, 4'd7, 3'b000);
      a_step("err.b0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("err.size_set", 128'(err_size), 128'(1'b1));
      drive_a(1, 1'b1, 3'd4, 4'd3, 3'b100);
      for (int i = 1; i < 8; i++) begin
         a_step($sformatf("err.b%0d", i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      end
      a_step("err.in1", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      drive_a(0, 1'b0, 3'd4, 4'd3, 3'b000);
      drive_a(1, 1'b0, 3'd4, 4'd3, 3'b100);
      a_step("err.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("err.src_sticky", 128'(err_source), 128'(1'b1));
      chk("err.size_sticky", 128'(err_size), 128'(1'b1));
      do_reset();
      chk("err.src_reset", 128'(err_source), 128'(1'b0));
      chk("err.size_reset", 128'(err_size), 128'(1'b0));

      // reset after beat 3 of an 8-beat burst, with rr_ptr at 1 beforehand
      drive_a(0, 1'b1, 3'd4, 4'd3, 3'b000);
      out_a_ready = 1'b1;
      a_step("mid.get", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      drive_a(0, 1'b1, 3'd0, 4'd6, 3'b000);
      for (int i = 0; i < 3; i++) begin
         a_step($sformatf("mid.b%0d", i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      end
      reset = 1'b1;
      drive_a(1, 1'b1, 3'd4, 4'd3, 3'b100);
      a_step("mid.inreset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      reset = 1'b0;
      drive_a(0, 1'b0, 3'd0, 4'd6, 3'b000);
      out_a_ready = 1'b0;
      a_step("mid.unlocked", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      drive_a(0, 1'b1, 3'd0, 4'd6, 3'b000);
      out_a_ready = 1'b1;
      a_step("mid.rr0", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
